// File: rtl/seq_mul_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Step counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mul.sv
// WIDTH x WIDTH shift-and-add multiplier, signed or unsigned, fixed WIDTH+1 cycle latency.
// start is only honoured in IDLE; done pulses once and p holds until the next done.
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("seq_mul: WIDTH must be in 2..32");
    end
  endgenerate

  state_t            state_q;
  logic              neg_q;
  logic [WIDTH-1:0]  mcand_q;
  logic [PW-1:0]     acc_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [PW-1:0]     p_q;

  logic [WIDTH-1:0]  a_mag_d;
  logic [WIDTH-1:0]  b_mag_d;
  logic [WIDTH-1:0]  addend_d;
  logic [WIDTH:0]    sum_d;
  logic [PW-1:0]     acc_d;
  logic [PW-1:0]     prod_d;

  // Upper half of acc accumulates; lower half holds the not-yet-consumed multiplier bits.
  always_comb begin
    a_mag_d  = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag_d  = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    addend_d = acc_q[0] ? mcand_q : '0;
    sum_d    = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend_d};
    acc_d    = {sum_d, acc_q[WIDTH-1:1]};
    prod_d   = neg_q ? (~acc_q + PW'(1)) : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            neg_q   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand_q <= a_mag_d;
            acc_q   <= {{WIDTH{1'b0}}, b_mag_d};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          p_q     <= prod_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: 8-bit and 16-bit instances checked every cycle against a transaction-level model.
module tb_seq_mul;

  logic        clk;
  logic        rst_n;
  logic        st8, sg8, st16, sg16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, busy16, done16;
  logic [15:0] p8;
  logic [31:0] p16;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // model state per instance: remaining cycles, pending product, expected outputs
  int          rem  [2];
  logic [63:0] pend [2];
  logic [63:0] ep   [2];
  bit          eb   [2];
  bit          ed   [2];

  seq_mul #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .sgn(sg8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  seq_mul #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .sgn(sg16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .p(p16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int wd(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic logic bsy(input int i);
    return (i == 0) ? busy8 : busy16;
  endfunction

  function automatic logic dn(input int i);
    return (i == 0) ? done8 : done16;
  endfunction

  function automatic logic [63:0] pv(input int i);
    return (i == 0) ? {48'h0, p8} : {32'h0, p16};
  endfunction

  function automatic logic [63:0] ref_mul(input int w, input bit s, input logic [15:0] x, input logic [15:0] y);
    longint xs, ys, m, mask;
    xs = longint'(x);
    ys = longint'(y);
    if (s && x[w-1]) xs = xs - (longint'(1) << w);
    if (s && y[w-1]) ys = ys - (longint'(1) << w);
    m    = xs * ys;
    mask = (longint'(1) << (2 * w)) - 1;
    return 64'(m & mask);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mstep(input int i, input bit rn, input bit s, input logic go,
                       input logic [15:0] x, input logic [15:0] y);
    if (!rn) begin
      rem[i] = 0; eb[i] = 0; ed[i] = 0; ep[i] = '0;
    end else begin
      ed[i] = 0;
      if (rem[i] == 0) begin
        if (go) begin
          rem[i]  = wd(i) + 1;
          pend[i] = ref_mul(wd(i), s, x, y);
          eb[i]   = 1;
        end
      end else begin
        rem[i]--;
        if (rem[i] == 0) begin
          ed[i] = 1;
          eb[i] = 0;
          ep[i] = pend[i];
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    mstep(0, rst_n, sg8, st8, {8'h0, a8}, {8'h0, b8});
    mstep(1, rst_n, sg16, st16, a16, b16);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk((i == 0) ? "busy8" : "busy16", 64'(bsy(i)), 64'(eb[i]));
        chk((i == 0) ? "done8" : "done16", 64'(dn(i)), 64'(ed[i]));
        chk((i == 0) ? "p8" : "p16", pv(i), ep[i]);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int i, input bit go, input bit s, input logic [15:0] x, input logic [15:0] y);
    if (i == 0) begin
      st8 = go; sg8 = s; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      st16 = go; sg16 = s; a16 = x; b16 = y;
    end
  endtask

  // n = edges after the current point until done is seen (0 if never), bc = busy cycles seen
  task automatic wait_done(input int i, output int n, output int bc);
    n  = 0;
    bc = bsy(i) ? 1 : 0;
    for (int k = 1; k <= 60; k++) begin
      tick;
      if (dn(i)) begin
        n = k;
        break;
      end
      if (bsy(i)) bc++;
    end
  endtask

  task automatic op(input int i, input bit s, input logic [15:0] x, input logic [15:0] y, input logic [31:0] exp);
    int n, bc;
    drive(i, 1, s, x, y);
    tick;
    drive(i, 0, ~s, x ^ 16'hA5A5, ~y);
    wait_done(i, n, bc);
    chk("latency", 64'(n), 64'(wd(i) + 1));
    chk("busy_cycles", 64'(bc), 64'(wd(i) + 1));
    chk("product", pv(i), {32'h0, exp});
  endtask

  task automatic b2b(input int i, input logic [15:0] x1, input logic [15:0] y1, input logic [31:0] e1,
                     input logic [15:0] x2, input logic [15:0] y2, input logic [31:0] e2);
    int n, bc;
    drive(i, 1, 0, x1, y1);
    tick;
    drive(i, 0, 0, 0, 0);
    wait_done(i, n, bc);
    chk("b2b_first", pv(i), {32'h0, e1});
    drive(i, 1, 0, x2, y2);
    tick;
    drive(i, 0, 0, 0, 0);
    wait_done(i, n, bc);
    chk("b2b_spacing", 64'(n + 1), 64'(wd(i) + 2));
    chk("b2b_second", pv(i), {32'h0, e2});
  endtask

  initial begin
    int n, bc, extra;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) tick;
    chk("reset_busy", 64'(busy8), 64'h0);
    chk("reset_done", 64'(done8), 64'h0);
    chk("reset_p16", 64'(p16), 64'h0);
    rst_n = 1'b1;
    chk_en = 1;
    tick;

    chk("model_signed", ref_mul(8, 1, 16'h0085, 16'h0003), 64'hFE8F);
    chk("model_minsq", ref_mul(16, 1, 16'h8000, 16'h8000), 64'h4000_0000);

    op(0, 0, 16'd13, 16'd11, 32'h008F);
    op(0, 0, 16'd255, 16'd255, 32'hFE01);
    op(0, 1, 16'h80, 16'h80, 32'h4000);
    op(0, 1, 16'hFF, 16'h7F, 32'hFF81);
    op(0, 1, 16'h85, 16'h03, 32'hFE8F);

    // start during RUN is dropped
    drive(0, 1, 0, 16'd3, 16'd4);
    tick;
    drive(0, 0, 0, 0, 0);
    repeat (3) tick;
    drive(0, 1, 0, 16'd5, 16'd5);
    tick;
    drive(0, 0, 0, 0, 0);
    wait_done(0, n, bc);
    chk("ignored_start_lat", 64'(n), 64'd5);
    chk("ignored_start_p", 64'(p8), 64'h000C);
    extra = 0;
    repeat (20) begin
      tick;
      if (done8) extra++;
    end
    chk("ignored_start_extra_done", 64'(extra), 64'd0);

    // reset mid-operation
    drive(0, 1, 0, 16'd7, 16'd9);
    tick;
    drive(0, 0, 0, 0, 0);
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 64'(busy8), 64'h0);
    chk("midreset_done", 64'(done8), 64'h0);
    chk("midreset_p", 64'(p8), 64'h0);
    tick;
    tick;
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin
      tick;
      if (done8) extra++;
    end
    chk("midreset_no_done", 64'(extra), 64'd0);
    op(0, 0, 16'd2, 16'd3, 32'd6);

    b2b(0, 16'd0, 16'd200, 32'd0, 16'd6, 16'd7, 32'd42);

    op(1, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    b2b(1, 16'd0, 16'd200, 32'd0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    op(1, 1, 16'h8000, 16'h8000, 32'h4000_0000);
    op(1, 1, 16'hFFFF, 16'h0003, 32'hFFFF_FFFD);

    repeat (3) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
# seq_mul

Parametrised sequential shift-and-add multiplier, the successor to the team's 8-bit repeated-addition multiplier. It is generalised to WIDTH-bit operands, adds a signed/unsigned mode, and has a fixed, data-independent latency. It uses a clean start/busy/done handshake and a single clock domain. It sits as an arithmetic slave behind any controller that can hold operands for one cycle and wait for `done`.

## Interface
- `WIDTH`, default 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `sgn`  in  1  mode, sampled with `start`: 1 = two's-complement operands, 0 = unsigned.
- `a`  in  WIDTH  multiplicand, sampled with `start`.
- `b`  in  WIDTH  multiplier, sampled with `start`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `p` is valid from this cycle on.
- `p`  out  2*WIDTH  product register; holds its value until the next `done`.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: performs WIDTH shift-add steps.
  - FIX: applies the sign and publishes the result.
- IDLE with `start`=1:
  - Latch `sgn`.
  - Latch |a| and |b| as WIDTH-bit magnitudes. When `sgn`=1 the magnitude is the two's-complement negation if the MSB is set; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
  - Latch neg = sgn & (a[MSB] ^ b[MSB]).
  - Clear the accumulator and step counter, then go to RUN.
- RUN, each cycle:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator. Use a (WIDTH+1)-bit sum so the carry is kept.
  - Shift the {carry, accumulator} pair right by one and increment the counter.
  - After WIDTH steps, go to FIX.
- FIX:
  - `p` <= neg ? (~acc + 1) : acc.
  - `done` = 1 for this cycle, then go to IDLE.
- All arithmetic is modulo 2^(2*WIDTH). Every signed product fits in 2*WIDTH bits, including (-2^(W-1))² = 2^(2W-2).
- `start` while busy (RUN or FIX) is ignored. No queueing, no error flag.
- Operand changes after the sampling edge have no effect.
- Zero operands take the full latency (no early exit).

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, `busy`=0, `done`=0, `p`=0, all internal registers 0.
- Let E0 be the edge that samples `start` in IDLE.
  - `busy`=1 from E0 until edge E(WIDTH+1).
  - `done`=1 and the new `p` appear at E(WIDTH+1).
  - Latency is WIDTH+1 cycles; `busy` is high for WIDTH+1 cycles.
- `done` cycle: state is already IDLE and `busy`=0, so a `start` in that cycle is accepted. This gives a throughput of one result per WIDTH+2 cycles.
- Reset asserted mid-operation: outputs are forced to their reset values immediately. The in-flight result is discarded and no `done` is produced.
- `done` never asserts without a preceding accepted `start`.

## Structure
- Package `seq_mul_pkg`:
  - state enum typedef (IDLE, RUN, FIX), 2 bits.
  - counter-width function clog2(WIDTH+1).
- Single module `seq_mul`; no sub-module is needed. Magnitude/negate logic is small inline combinational code.
- Elaboration check: WIDTH in 2..32.

## Test plan
- WIDTH=8, sgn=0, a=13, b=11 -> `p`=0x008F, `done` exactly 9 cycles after E0, `busy` high 9 cycles.
- sgn=0, a=255, b=255 -> `p`=0xFE01; sgn=1, a=0x80, b=0x80 -> `p`=0x4000.
- sgn=1, a=0xFF (-1), b=0x7F -> `p`=0xFF81; sgn=1, a=0x85 (-123), b=0x03 -> `p`=0xFE8F.
- Start 3*4 (sgn=0), then pulse `start` with 5*5 at cycle 4 -> single `done`, `p`=0x000C; the second request is ignored.
- Start 7*9 and assert `rst_n`=0 at cycle 4 -> `busy`/`done`/`p` drop to 0 at once, no later `done`. After release, 2*3 -> `p`=6.
- 0*200 then back-to-back `start` on the `done` cycle with 6*7 -> `p`=0, then `p`=42 exactly WIDTH+2 cycles later. Repeat at WIDTH=16 with 0xFFFF*0xFFFF -> 0xFFFE0001.
